// File: rtl/fifo_rd_stream.sv
// Async FIFO read-domain output stage: 2-entry prefetch buffer to valid/ready.
// Optional occupancy output o_level enabled by FIFO_RD_STREAM_LEVEL_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int LVL_WIDTH  = 2
) (
  input  logic                  i_Rclk,
  input  logic                  i_Rrst_n,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_R_en,
  output logic                  o_valid,
  input  logic                  i_ready,
`ifdef FIFO_RD_STREAM_LEVEL_EN
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LVL_WIDTH-1:0]  o_level
`else
  output logic [DATA_WIDTH-1:0] o_data
`endif
);

  logic [LVL_WIDTH-1:0]  count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_idx_q, wr_idx_d;
  logic                  rd_idx_q, rd_idx_d;
  logic [DATA_WIDTH-1:0] ent_q [2];
  logic [DATA_WIDTH-1:0] ent_d [2];

  logic                  push;
  logic                  pop;
  logic [LVL_WIDTH:0]    occ;

  assign push    = inflight_q;
  assign o_valid = (count_q != '0);
  assign pop     = o_valid & i_ready;
  assign o_data  = ent_q[rd_idx_q];

  // Occupancy after this cycle's pop, including the word already in flight
  always_comb begin
    occ = {1'b0, count_q}
        + (LVL_WIDTH+1)'(inflight_q)
        - (LVL_WIDTH+1)'(pop);
    o_R_en = !i_empty & (occ < (LVL_WIDTH+1)'(2));
  end

  always_comb begin
    inflight_d = o_R_en;
    count_d    = count_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
    wr_idx_d   = wr_idx_q ^ push;
    rd_idx_d   = rd_idx_q ^ pop;
    ent_d      = ent_q;
    if (push) begin
      ent_d[wr_idx_q] = i_rdata;
    end
  end

  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      ent_q[0]   <= ent_d[0];
      ent_q[1]   <= ent_d[1];
    end
  end

`ifdef FIFO_RD_STREAM_LEVEL_EN
  assign o_level = count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized + directed bench for fifo_rd_stream against a queue-based
// model of the upstream FIFO and the stream order.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rst_n;
  logic       i_empty;
  logic [7:0] i_rdata;
  logic       o_R_en;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
`ifdef FIFO_RD_STREAM_LEVEL_EN
  logic [1:0] o_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       gate_empty;
  logic       inflight_m;
  logic       stall_prev;
  logic [7:0] prev_dat;
  logic       last_ren, last_vld, last_pop;
  logic [7:0] last_dat;
  int         nxt;

  fifo_rd_stream dut (
    .i_Rclk  (clk),
    .i_Rrst_n(rst_n),
    .i_empty (i_empty),
    .i_rdata (i_rdata),
    .o_R_en  (o_R_en),
    .o_valid (o_valid),
    .i_ready (i_ready),
`ifdef FIFO_RD_STREAM_LEVEL_EN
    .o_data  (o_data),
    .o_level (o_level)
`else
    .o_data  (o_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    i_empty = gate_empty | (src_q.size() == 0);
  endtask

  // One clock: sample/check at negedge, model the upstream FIFO at posedge
  task automatic cycle();
    int cnt;
    @(negedge clk);
    cnt      = exp_q.size() - int'(inflight_m);
    last_ren = o_R_en;
    last_vld = o_valid;
    last_dat = o_data;
    last_pop = o_valid & i_ready;
    chk("ren_while_empty", {31'd0, last_ren & i_empty}, 0);
    chk("occupancy_le2", {31'd0, exp_q.size() > 2}, 0);
    chk("valid", {31'd0, last_vld}, {31'd0, cnt != 0});
`ifdef FIFO_RD_STREAM_LEVEL_EN
    chk("level", {30'd0, o_level}, cnt);
`endif
    if (stall_prev) begin
      chk("hold_valid", {31'd0, last_vld}, 1);
      chk("hold_data", {24'd0, last_dat}, {24'd0, prev_dat});
    end
    if (last_pop) begin
      if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
      else chk("data", {24'd0, last_dat}, {24'd0, exp_q.pop_front()});
    end
    stall_prev = last_vld & !i_ready;
    prev_dat   = last_dat;
    @(posedge clk);
    #1;
    inflight_m = last_ren;
    if (last_ren && src_q.size() != 0) begin
      i_rdata = src_q.pop_front();
      exp_q.push_back(i_rdata);
    end else begin
      i_rdata = 8'($urandom);
    end
    upd_empty();
  endtask

  // Called at posedge+1; asserts reset mid-cycle
  task automatic do_reset();
    #2;
    rst_n   = 1'b0;
    gate_empty = 1'b1;
    i_empty = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_ren", {31'd0, o_R_en}, 0);
`ifdef FIFO_RD_STREAM_LEVEL_EN
    chk("rst_level", {30'd0, o_level}, 0);
`endif
    exp_q.delete();
    inflight_m = 1'b0;
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gate_empty = 1'b0;
    upd_empty();
  endtask

  initial begin
    int p_exp;
    bit got;
    rst_n      = 1'b0;
    i_empty    = 1'b1;
    i_ready    = 1'b1;
    i_rdata    = 8'h00;
    gate_empty = 1'b0;
    inflight_m = 1'b0;
    stall_prev = 1'b0;
    prev_dat   = 8'h00;
    nxt        = 8'h50;
    #12;
    chk("reset_valid", {31'd0, o_valid}, 0);
    chk("reset_data", {24'd0, o_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_ren", {31'd0, last_ren}, 0);
      chk("idle_data", {24'd0, last_dat}, 0);
    end

    // single word latency
    src_q.push_back(8'hA5);
    upd_empty();
    cycle();
    chk("sw_ren_n", {31'd0, last_ren}, 1);
    chk("sw_vld_n", {31'd0, last_vld}, 0);
    cycle();
    chk("sw_ren_n1", {31'd0, last_ren}, 0);
    chk("sw_vld_n1", {31'd0, last_vld}, 0);
    cycle();
    chk("sw_vld_n2", {31'd0, last_vld}, 1);
    chk("sw_dat_n2", {24'd0, last_dat}, 32'hA5);
    cycle();
    chk("sw_vld_n3", {31'd0, last_vld}, 0);

    // full-rate burst
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    upd_empty();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (i < 8) chk("burst_ren", {31'd0, last_ren}, 1);
      p_exp = (i >= 2 && i <= 9) ? 1 : 0;
      chk("burst_pop", {31'd0, last_pop}, p_exp);
    end

    // backpressure mid-burst
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h10 + i));
    upd_empty();
    for (int i = 0; i < 24; i++) begin
      i_ready = !(i >= 3 && i <= 6);
      cycle();
      if (i == 6) begin
        chk("bp_ren_stop", {31'd0, last_ren}, 0);
        chk("bp_vld", {31'd0, last_vld}, 1);
      end
    end
    chk("bp_drain", exp_q.size(), 0);

    // empty rises with a word in flight and sink stalled
    i_ready = 1'b0;
    src_q.push_back(8'h30);
    src_q.push_back(8'h31);
    upd_empty();
    repeat (4) cycle();
    chk("er_full", exp_q.size(), 2);
    chk("er_vld", {31'd0, last_vld}, 1);
    i_ready = 1'b1;
    repeat (3) cycle();
    chk("er_drained", {31'd0, last_vld}, 0);

    // async reset with a full buffer
    i_ready = 1'b0;
    src_q.push_back(8'h40);
    src_q.push_back(8'h41);
    src_q.push_back(8'h42);
    upd_empty();
    repeat (4) cycle();
    chk("rst_pre_full", exp_q.size(), 2);
    do_reset();
    i_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (last_pop) begin
        got = 1'b1;
        chk("rst_next_word", {24'd0, last_dat}, 32'h42);
      end
    end
    if (!got) chk("rst_next_timeout", 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) gate_empty = ~gate_empty;
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(8'(nxt));
        nxt++;
      end
      upd_empty();
      if ($urandom_range(0, 149) == 0) do_reset();
      cycle();
    end

    // final drain
    gate_empty = 1'b1;
    i_ready    = 1'b1;
    upd_empty();
    repeat (6) cycle();
    chk("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
